// File: rtl/link_pkg.sv
// Shared definitions for the 3x3 byte-matrix link (transmit and receive sides).
package link_pkg;

  localparam int N_ELEMS = 9;
  localparam int DATA_W  = 8;
  localparam int IDX_W   = (N_ELEMS > 1) ? $clog2(N_ELEMS) : 1;

  typedef logic [DATA_W-1:0] byte_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_e;

endpackage

// File: rtl/matrix_tx.sv
// Transmit side of the byte-matrix link: captures a whole matrix on i_start and
// streams it row-major, one element per valid/ready beat, with an optional idle gap.
module matrix_tx
  import link_pkg::state_e, link_pkg::S_IDLE, link_pkg::S_SEND, link_pkg::S_GAP;
#(
  parameter int N_ELEMS = link_pkg::N_ELEMS,
  parameter int DATA_W  = link_pkg::DATA_W,
  parameter int GAP     = 0,
  localparam int IDX_W  = (N_ELEMS > 1) ? $clog2(N_ELEMS) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic [N_ELEMS*DATA_W-1:0] i_mat,
  output logic [DATA_W-1:0]         o_data,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [IDX_W-1:0]          o_idx
);

  localparam int CNT_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEMS - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP);

  typedef logic [DATA_W-1:0] elem_t;

  state_e           state_q, state_d;
  elem_t            shadow_q [N_ELEMS];
  elem_t            shadow_d [N_ELEMS];
  logic [IDX_W-1:0] idx_q, idx_d, idx_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  elem_t            data_q, data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             handshake, last_elem;

  assign handshake = valid_q & i_ready;
  assign last_elem = (idx_q == LAST_IDX);
  assign idx_inc   = idx_q + IDX_W'(1);

  // NOTE: sequential state is updated only with non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every variable written in a combinational block gets a default first,
  // otherwise an uncovered path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (i_start) state_d = S_SEND;
      S_SEND: begin
        if (handshake) begin
          if (last_elem)    state_d = S_IDLE;
          else if (GAP > 0) state_d = S_GAP;
        end
      end
      S_GAP:   if (cnt_q == CNT_W'(1)) state_d = S_SEND;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    shadow_d = shadow_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          for (int k = 0; k < N_ELEMS; k++) shadow_d[k] = i_mat[DATA_W*k +: DATA_W];
          idx_d   = '0;
          data_d  = i_mat[DATA_W-1:0];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_SEND: begin
        if (handshake) begin
          if (last_elem) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (GAP == 0) begin
            idx_d  = idx_inc;
            data_d = shadow_q[idx_inc];
          end else begin
            valid_d = 1'b0;
            cnt_d   = GAP_LOAD;
          end
        end
      end
      S_GAP: begin
        cnt_d = cnt_q - CNT_W'(1);
        // The gap ends on the edge where the counter reads 1, giving exactly GAP idle cycles.
        if (cnt_q == CNT_W'(1)) begin
          idx_d   = idx_inc;
          data_d  = shadow_q[idx_inc];
          valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // NOTE: the shadow copy is a handful of flops, not a RAM, so it is reset
  // along with the rest of the datapath to keep o_data deterministic.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < N_ELEMS; k++) shadow_q[k] <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_idx   = idx_q;

endmodule

// File: tb/tb_matrix_tx.sv
// Bench for matrix_tx: two instances (GAP=0 and GAP=2) share one stimulus stream
// and are compared every cycle against a transfer-level model of the link.
module tb_matrix_tx;

  localparam int N  = 9;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          ready = 1'b0;
  logic [N*DW-1:0] mat = '0;

  logic [DW-1:0] data_a, data_b;
  logic          valid_a, valid_b, busy_a, busy_b, done_a, done_b;
  logic [3:0]    idx_a, idx_b;

  always #5 clk = ~clk;

  matrix_tx #(.N_ELEMS(N), .DATA_W(DW), .GAP(0)) u_dut_g0 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_mat(mat),
    .o_data(data_a), .o_valid(valid_a), .i_ready(ready),
    .o_busy(busy_a), .o_done(done_a), .o_idx(idx_a)
  );

  matrix_tx #(.N_ELEMS(N), .DATA_W(DW), .GAP(2)) u_dut_g2 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_mat(mat),
    .o_data(data_b), .o_valid(valid_b), .i_ready(ready),
    .o_busy(busy_b), .o_done(done_b), .o_idx(idx_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference model: per instance, a captured matrix, the position being offered,
  // whether a byte is on offer, and how many idle cycles remain before the next one.
  bit         m_busy [2];
  bit         m_valid[2];
  bit         m_done [2];
  int         m_pos  [2];
  int         m_wait [2];
  logic [7:0] m_data [2];
  logic [7:0] m_mat  [2][N];

  task automatic model_step(input int u, input bit s, input bit r, input bit rs,
                            input logic [N*DW-1:0] m);
    int g;
    g = (u == 0) ? 0 : 2;
    if (rs) begin
      m_busy[u] = 0; m_valid[u] = 0; m_done[u] = 0;
      m_pos[u] = 0; m_wait[u] = 0; m_data[u] = '0;
      for (int k = 0; k < N; k++) m_mat[u][k] = '0;
      return;
    end
    m_done[u] = 0;
    if (!m_busy[u]) begin
      if (s) begin
        for (int k = 0; k < N; k++) m_mat[u][k] = m[8*k +: 8];
        m_pos[u] = 0; m_data[u] = m_mat[u][0];
        m_valid[u] = 1; m_busy[u] = 1;
      end
    end else if (m_valid[u]) begin
      if (r) begin
        if (m_pos[u] == N - 1) begin
          m_valid[u] = 0; m_busy[u] = 0; m_done[u] = 1;
        end else if (g == 0) begin
          m_pos[u]++; m_data[u] = m_mat[u][m_pos[u]];
        end else begin
          m_valid[u] = 0; m_wait[u] = g;
        end
      end
    end else begin
      m_wait[u]--;
      if (m_wait[u] == 0) begin
        m_pos[u]++; m_data[u] = m_mat[u][m_pos[u]]; m_valid[u] = 1;
      end
    end
  endtask

  function automatic logic [31:0] expect_out(input int u);
    return {17'b0, m_data[u], m_valid[u], m_busy[u], m_done[u], 4'(m_pos[u])};
  endfunction

  int cyc;
  int done_cnt[2];
  int done_cyc[2];
  int hs[2];

  task automatic clear_stats();
    cyc = 0;
    for (int u = 0; u < 2; u++) begin
      done_cnt[u] = 0; done_cyc[u] = -1; hs[u] = 0;
    end
  endtask

  // One cycle: compare outputs, drive this cycle's inputs, advance the model past the edge.
  task automatic tick(input bit s, input bit r, input bit rs, input logic [N*DW-1:0] m);
    @(negedge clk);
    check("outputs_gap0", {17'b0, data_a, valid_a, busy_a, done_a, idx_a}, expect_out(0));
    check("outputs_gap2", {17'b0, data_b, valid_b, busy_b, done_b, idx_b}, expect_out(1));
    if (done_a) begin done_cnt[0]++; done_cyc[0] = cyc; end
    if (done_b) begin done_cnt[1]++; done_cyc[1] = cyc; end
    start = s; ready = r; rst = rs; mat = m;
    if (valid_a && r && !rs) hs[0]++;
    if (valid_b && r && !rs) hs[1]++;
    model_step(0, s, r, rs, m);
    model_step(1, s, r, rs, m);
    cyc++;
  endtask

  task automatic reset_seq();
    tick(0, 1, 1, '0);
    tick(0, 1, 1, '0);
    clear_stats();
  endtask

  logic [N*DW-1:0] seq, all_aa, all_ff, rnd;

  initial begin
    for (int k = 0; k < N; k++) seq[8*k +: 8] = 8'(k + 1);
    all_aa = {N{8'hAA}};
    all_ff = {N{8'hFF}};
    model_step(0, 0, 0, 1, '0);
    model_step(1, 0, 0, 1, '0);
    repeat (2) @(posedge clk);

    // Back-to-back transfer with the sink always ready.
    reset_seq();
    for (int c = 0; c < 30; c++) tick(c == 0, 1, 0, seq);
    check("t1_done_cycle_gap0", 32'(done_cyc[0]), 32'd10);
    check("t1_done_cycle_gap2", 32'(done_cyc[1]), 32'd26);
    check("t1_handshakes_gap0", 32'(hs[0]), 32'd9);
    check("t1_handshakes_gap2", 32'(hs[1]), 32'd9);
    check("t1_done_count_gap0", 32'(done_cnt[0]), 32'd1);

    // Backpressure in cycles 4-6.
    reset_seq();
    for (int c = 0; c < 30; c++) tick(c == 0, !(c >= 4 && c <= 6), 0, seq);
    check("t2_done_cycle_gap0", 32'(done_cyc[0]), 32'd13);
    check("t2_handshakes_gap0", 32'(hs[0]), 32'd9);

    // Equal consecutive bytes separated by the gap.
    reset_seq();
    for (int c = 0; c < 30; c++) tick(c == 0, 1, 0, all_aa);
    check("t3_done_cycle_gap2", 32'(done_cyc[1]), 32'd26);
    check("t3_handshakes_gap2", 32'(hs[1]), 32'd9);

    // Restart and input change during a transfer are ignored.
    reset_seq();
    for (int c = 0; c < 32; c++) tick(c == 0 || c == 3, 1, 0, (c >= 2) ? all_ff : seq);
    check("t4_done_count_gap0", 32'(done_cnt[0]), 32'd1);
    check("t4_done_count_gap2", 32'(done_cnt[1]), 32'd1);

    // Reset mid-transfer aborts without done, then a fresh transfer starts from element 0.
    reset_seq();
    for (int c = 0; c < 20; c++) tick(c == 0, 1, c == 5, seq);
    check("t5_no_done_gap0", 32'(done_cnt[0]), 32'd0);
    check("t5_no_done_gap2", 32'(done_cnt[1]), 32'd0);
    for (int c = 20; c < 50; c++) tick(c == 20, 1, 0, all_aa);
    check("t5_restart_done_gap0", 32'(done_cnt[0]), 32'd1);

    // Start in the done cycle is accepted with the newly presented matrix.
    reset_seq();
    for (int c = 0; c < 40; c++) tick(c == 0 || c == 10, 1, 0, (c >= 10) ? all_aa : seq);
    check("t6_done_count_gap0", 32'(done_cnt[0]), 32'd2);

    // Randomized traffic: sparse starts, random backpressure, occasional reset.
    reset_seq();
    for (int c = 0; c < 800; c++) begin
      rnd = (N*DW)'({$urandom(), $urandom(), $urandom()});
      tick($urandom_range(0, 7) == 0, $urandom_range(0, 9) < 7,
           $urandom_range(0, 149) == 0, rnd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
